// File: rtl/vga_digit_overlay.sv
// VGA scan generator with an N-digit BCD glyph overlay and blink.
// Stage 0 holds the scan counters, stage 1 registers the font ROM address,
// and stage 2 lines up with the ROM data so every pin output is 2 clocks late.
module vga_digit_overlay #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned ORIGIN_X   = 256,
  parameter int unsigned ORIGIN_Y   = 208,
  parameter int unsigned BLINK_DIV  = 50000000,
  parameter logic [2:0]  FG_RGB     = 3'b010,
  parameter logic [2:0]  BG_RGB     = 3'b000
) (
  input  logic                    clk_100MHz,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic                    finish,
  output logic [10:0]             font_addr,
  input  logic [7:0]              font_word,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    video_on,
  output logic [2:0]              rgb,
  output logic [NUM_DIGITS-1:0]   text_on,
  output logic [9:0]              pixel_x,
  output logic [9:0]              pixel_y,
  output logic                    frame_start
);

  localparam int unsigned H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START    = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END      = HS_START + H_SYNC;
  localparam int unsigned VS_START    = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END      = VS_START + V_SYNC;
  localparam int unsigned CELL_W      = 8 << SCALE_LOG2;
  localparam int unsigned CELL_H      = 16 << SCALE_LOG2;
  localparam int unsigned FIELD_X_END = ORIGIN_X + NUM_DIGITS * CELL_W;
  localparam int unsigned FIELD_Y_END = ORIGIN_Y + CELL_H;
  localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BLINK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic [9:0]              x;
  logic [9:0]              y;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_on;

  logic [31:0]             xw, yw, rel_x, rel_y, slot_c;
  logic                    in_field_c, hs_c, vs_c, vid_c;
  logic [2:0]              col_c;
  logic [3:0]              row_c, bcd_c;
  logic [6:0]              char_c;
  logic [NUM_DIGITS-1:0]   text_c;

  logic                    in_field_1, hs_1, vs_1, vid_1;
  logic [2:0]              col_1;
  logic [NUM_DIGITS-1:0]   text_1;
  logic                    in_field_2;
  logic [2:0]              col_2;
  logic                    pix;

  // A single divider slot yields a tick on every clock.
  assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign pixel_x     = x;
  assign pixel_y     = y;
  assign frame_start = tick & (x == '0) & (y == '0);

  // Pixel-tick divider.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Horizontal and vertical scan counters, advanced once per pixel tick.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (tick) begin
      if (x == 10'(H_TOTAL - 1)) begin
        x <= '0;
        if (y == 10'(V_TOTAL - 1)) y <= '0;
        else                       y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Digits are captured only at frame start so a frame never mixes two values.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)         shadow <= '0;
    else if (frame_start) shadow <= digits_bcd;
  end

  // Blink phase: held on while finish is low, toggles every BLINK_DIV clocks otherwise.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!finish) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Map the current scan position onto a digit cell, glyph row/column and sync levels.
  always_comb begin
    xw         = {22'd0, x};
    yw         = {22'd0, y};
    rel_x      = xw - ORIGIN_X;
    rel_y      = yw - ORIGIN_Y;
    in_field_c = (xw >= ORIGIN_X) && (xw < FIELD_X_END) &&
                 (yw >= ORIGIN_Y) && (yw < FIELD_Y_END);
    slot_c     = rel_x >> (3 + SCALE_LOG2);
    col_c      = 3'(rel_x >> SCALE_LOG2);
    row_c      = 4'(rel_y >> SCALE_LOG2);
    text_c     = '0;
    bcd_c      = '0;
    // Slot 0 is the leftmost cell and shows the most significant digit.
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (in_field_c && (slot_c == NUM_DIGITS - 1 - k)) begin
        text_c[k] = 1'b1;
        bcd_c     = shadow[4*k +: 4];
      end
    end
    char_c = (bcd_c <= 4'd9) ? {3'b011, bcd_c} : 7'h20;
    hs_c   = !((xw >= HS_START) && (xw < HS_END));
    vs_c   = !((yw >= VS_START) && (yw < VS_END));
    vid_c  = (xw < H_DISPLAY) && (yw < V_DISPLAY);
  end

  // Stage 1: font ROM address plus the pixel attributes that travel with it.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      font_addr  <= '0;
      in_field_1 <= 1'b0;
      col_1      <= '0;
      hs_1       <= 1'b1;
      vs_1       <= 1'b1;
      vid_1      <= 1'b0;
      text_1     <= '0;
    end else begin
      font_addr  <= in_field_c ? {char_c, row_c} : '0;
      in_field_1 <= in_field_c;
      col_1      <= col_c;
      hs_1       <= hs_c;
      vs_1       <= vs_c;
      vid_1      <= vid_c;
      text_1     <= text_c;
    end
  end

  // Stage 2: aligns the attributes with the ROM word arriving one clock later.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      in_field_2 <= 1'b0;
      col_2      <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      text_on    <= '0;
    end else begin
      in_field_2 <= in_field_1;
      col_2      <= col_1;
      hsync      <= hs_1;
      vsync      <= vs_1;
      video_on   <= vid_1;
      text_on    <= text_1;
    end
  end

  // Colour select; the ROM word is used straight off the ROM output register.
  always_comb begin
    pix = font_word[3'd7 - col_2] & in_field_2 & blink_on;
    rgb = '0;
    if (video_on) rgb = pix ? FG_RGB : BG_RGB;
  end

endmodule

// File: tb/tb_vga_digit_overlay.sv
// Bench for vga_digit_overlay on a shrunken raster: a cycle-indexed reference
// model checks every output each clock, and literal checks pin key points.
module tb_vga_digit_overlay;

  localparam int ND = 3;
  localparam int CD = 2;
  localparam int HD = 64, HF = 4, HS = 8, HB = 4;
  localparam int VD = 40, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int SL = 1;
  localparam int SC = 1 << SL;
  localparam int CW = 8 * SC;
  localparam int CH = 16 * SC;
  localparam int OX = 8, OY = 4;
  localparam int BD = 100;
  localparam logic [2:0] FG = 3'b110;
  localparam logic [2:0] BG = 3'b001;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [4*ND-1:0] digits_bcd = '0;
  logic           finish = 1'b0;
  logic [10:0]    font_addr;
  logic [7:0]     font_word;
  logic           hsync, vsync, video_on, frame_start;
  logic [2:0]     rgb;
  logic [ND-1:0]  text_on;
  logic [9:0]     pixel_x, pixel_y;

  logic [7:0]     rom [0:2047];

  int checks = 0;
  int errors = 0;

  vga_digit_overlay #(
    .NUM_DIGITS(ND), .CLK_DIV(CD),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SCALE_LOG2(SL), .ORIGIN_X(OX), .ORIGIN_Y(OY), .BLINK_DIV(BD),
    .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .clk_100MHz(clk), .reset_n(reset_n), .digits_bcd(digits_bcd), .finish(finish),
    .font_addr(font_addr), .font_word(font_word), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .rgb(rgb), .text_on(text_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous font ROM with one clock of read latency.
  always @(posedge clk) font_word <= rom[font_addr];

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (cycle index -> raster) ----------------
  function automatic void coords(input int k, output int x, output int y);
    int p;
    p = (k / CD) % FRAME;
    x = p % HT;
    y = p / HT;
  endfunction

  function automatic bit fs_at(input int k);
    return (k % CD == CD - 1) && ((k / CD) % FRAME == 0);
  endfunction

  function automatic bit in_field(input int x, input int y);
    return x >= OX && x < OX + ND * CW && y >= OY && y < OY + CH;
  endfunction

  function automatic int slot_of(input int x);
    return (x - OX) / CW;
  endfunction

  function automatic int col_of(input int x);
    return (((x - OX) % CW) / SC) % 8;
  endfunction

  function automatic logic [10:0] addr_of(input int k, input logic [4*ND-1:0] sh);
    int x, y, d, bcd, ch, row;
    if (k < 0) return '0;
    coords(k, x, y);
    if (!in_field(x, y)) return '0;
    d   = ND - 1 - slot_of(x);
    bcd = int'((sh >> (4 * d)) & 12'hF);
    ch  = (bcd <= 9) ? 'h30 + bcd : 'h20;
    row = ((y - OY) / SC) % 16;
    return 11'(ch * 16 + row);
  endfunction

  // Compare process: one sample per clock, 1 time unit after the rising edge.
  initial begin
    int c = 0;
    int bcnt = 0;
    bit bon = 1'b1;
    logic [4*ND-1:0] sh_cur = '0;
    logic [4*ND-1:0] sh_prev;
    logic [10:0] addr_last = '0;
    logic [10:0] ea;
    logic [7:0] rw;
    int x, y;
    bit f, pixv, e_hs, e_vs, e_vid;
    logic [ND-1:0] e_txt;
    logic [2:0] e_rgb;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        c = 0; bcnt = 0; bon = 1'b1; sh_cur = '0; addr_last = '0;
        chk("rst_sync", {30'd0, hsync, vsync}, 32'h3);
        chk("rst_video_rgb_text", {video_on, rgb, text_on}, 32'h0);
        chk("rst_font_addr", font_addr, 32'h0);
        chk("rst_counters", {frame_start, pixel_x, pixel_y}, 32'h0);
        continue;
      end
      c++;
      sh_prev = sh_cur;
      if (fs_at(c - 1)) sh_cur = digits_bcd;
      if (!finish) begin
        bcnt = 0; bon = 1'b1;
      end else begin
        bcnt++;
        if (bcnt == BD) begin bcnt = 0; bon = !bon; end
      end
      coords(c, x, y);
      chk("pixel_x", pixel_x, x);
      chk("pixel_y", pixel_y, y);
      chk("frame_start", frame_start, fs_at(c));
      ea = addr_of(c - 1, sh_prev);
      chk("font_addr", font_addr, ea);
      if (c >= 2) begin
        coords(c - 2, x, y);
        f     = in_field(x, y);
        e_hs  = !(x >= HD + HF && x < HD + HF + HS);
        e_vs  = !(y >= VD + VF && y < VD + VF + VS);
        e_vid = (x < HD) && (y < VD);
        e_txt = f ? ND'(1 << (ND - 1 - slot_of(x))) : '0;
        rw    = rom[addr_last];
        pixv  = f && bon && rw[7 - col_of(x)];
        e_rgb = !e_vid ? 3'b000 : (pixv ? FG : BG);
      end else begin
        e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0; e_txt = '0; e_rgb = '0;
      end
      chk("hsync", hsync, e_hs);
      chk("vsync", vsync, e_vs);
      chk("video_on", video_on, e_vid);
      chk("text_on", text_on, e_txt);
      chk("rgb", rgb, e_rgb);
      addr_last = ea;
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic wait_pix(input int px, input int py);
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(pixel_x == 10'(px) && pixel_y == 10'(py)) && n < 20000);
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL wait_pix timeout: pixel (%0d,%0d) never reached", px, py);
    end
  endtask

  task automatic lit_glyph(input string name, input int px, input int py,
                           input logic [10:0] e_addr, input logic [ND-1:0] e_txt);
    wait_pix(px, py);
    @(posedge clk); #1;
    chk({name, "_addr"}, font_addr, e_addr);
    @(posedge clk); #1;
    chk({name, "_text"}, text_on, e_txt);
  endtask

  initial begin
    int n, hl, vl, ph;
    logic [7:0] w;
    digits_bcd = 12'h1A7;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Glyph addressing and cell selection for digits 1, A (blank), 7.
    wait_pix(8, 4);
    @(posedge clk); #1;
    chk("lit_8_4_addr", font_addr, 11'h310);
    @(posedge clk); #1;
    chk("lit_8_4_text", text_on, 3'b100);
    w = rom[11'h310];
    chk("lit_8_4_rgb", rgb, w[7] ? FG : BG);
    lit_glyph("lit_56_4", 56, 4, 11'h000, 3'b000);
    lit_glyph("lit_24_6", 24, 6, 11'h201, 3'b010);
    lit_glyph("lit_40_35", 40, 35, 11'h37F, 3'b001);
    lit_glyph("lit_7_10", 7, 10, 11'h000, 3'b000);

    // One full frame of raster timing.
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!frame_start && n < 20000);
    n = 0; hl = 0; vl = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!hsync) hl++;
      if (!vsync) vl++;
    end while (!frame_start && n < 20000);
    chk("frame_period", n, CD * FRAME);
    chk("hsync_low_per_frame", hl, CD * HS * VT);
    chk("vsync_low_per_frame", vl, CD * VS * HT);

    // Mid-frame digit change stays hidden until the next frame.
    wait_pix(0, 20);
    @(negedge clk);
    digits_bcd = 12'h905;
    lit_glyph("tear_same_frame", 8, 22, 11'h319, 3'b100);
    lit_glyph("tear_next_frame", 8, 4, 11'h390, 3'b100);

    // Blink: drop finish 150 clocks in, while the phase is off.
    @(negedge clk);
    finish = 1'b1;
    repeat (150) @(negedge clk);
    finish = 1'b0;

    // Randomised digits and blink episodes.
    ph = 200;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) digits_bcd = 12'($urandom);
      if (ph == 0) begin
        finish = !finish;
        ph = finish ? int'($urandom_range(120, 450)) : int'($urandom_range(30, 250));
      end else begin
        ph--;
      end
    end

    // Asynchronous reset in the middle of a visible line.
    wait_pix(40, 10);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_sync", {30'd0, hsync, vsync}, 32'h3);
    chk("async_rst_video_rgb_text", {video_on, rgb, text_on}, 32'h0);
    chk("async_rst_font_addr", font_addr, 32'h0);
    chk("async_rst_counters", {frame_start, pixel_x, pixel_y}, 32'h0);
    finish = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_x", pixel_x, 32'd0);
    chk("post_rst_hsync", hsync, 32'd1);

    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) digits_bcd = 12'($urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
